// File: rtl/hc595.sv
// Cycle-based 74HC595: serial-in shift register feeding a tri-state output latch,
// with every pin clock sampled on clk and its rising edge detected digitally.
module hc595 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic p14,
  input  logic p11,
  input  logic p12,
  input  logic p10,
  input  logic p13,
  output logic p15,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p5,
  output logic p6,
  output logic p7,
  output logic p9
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] ser_sync;
  logic [SYNC_STAGES-1:0] srclk_sync;
  logic [SYNC_STAGES-1:0] rclk_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   srclk_hist;
  logic                   rclk_hist;
  logic                   primed;
  logic [CW-1:0]          prime_cnt;
  logic [7:0]             sr;
  logic [7:0]             st;

  logic ser_s;
  logic srclk_s;
  logic rclk_s;
  logic clr_n_s;
  logic rise_sr;
  logic rise_st;

  assign ser_s   = ser_sync[SYNC_STAGES-1];
  assign srclk_s = srclk_sync[SYNC_STAGES-1];
  assign rclk_s  = rclk_sync[SYNC_STAGES-1];
  assign clr_n_s = clr_sync[SYNC_STAGES-1];

  // SER and SRCLK share the same depth so data stays aligned with its edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_sync   <= '0;
      srclk_sync <= '0;
      rclk_sync  <= '0;
      clr_sync   <= '0;
      srclk_hist <= 1'b0;
      rclk_hist  <= 1'b0;
    end else begin
      ser_sync   <= {ser_sync[SYNC_STAGES-2:0], p14};
      srclk_sync <= {srclk_sync[SYNC_STAGES-2:0], p11};
      rclk_sync  <= {rclk_sync[SYNC_STAGES-2:0], p12};
      clr_sync   <= {clr_sync[SYNC_STAGES-2:0], p10};
      srclk_hist <= srclk_s;
      rclk_hist  <= rclk_s;
    end
  end

  // Edges stay masked until the chains and history flops have caught up with the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 1'b1;
      if (prime_cnt == CW'(SYNC_STAGES))
        primed <= 1'b1;
    end
  end

  assign rise_sr = primed & srclk_s & ~srclk_hist;
  assign rise_st = primed & rclk_s & ~rclk_hist;

  // Latch reads the pre-edge sr, so a simultaneous shift or clear is not seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      st <= '0;
    end else begin
      if (!clr_n_s)
        sr <= '0;
      else if (rise_sr)
        sr <= {sr[6:0], ser_s};
      if (rise_st)
        st <= sr;
    end
  end

  assign p15 = p13 ? 1'bz : st[0];
  assign p1  = p13 ? 1'bz : st[1];
  assign p2  = p13 ? 1'bz : st[2];
  assign p3  = p13 ? 1'bz : st[3];
  assign p4  = p13 ? 1'bz : st[4];
  assign p5  = p13 ? 1'bz : st[5];
  assign p6  = p13 ? 1'bz : st[6];
  assign p7  = p13 ? 1'bz : st[7];
  assign p9  = sr[7];

endmodule

// File: tb/tb_hc595.sv
// Directed bench for hc595: a vector table for the load/latch/clear/enable flow plus
// hand sequences for priming, tied clocks and mid-load reset.
module tb_hc595;

  localparam int OP_SHIFT8 = 0;
  localparam int OP_LATCH  = 1;
  localparam int OP_CLEAR  = 2;
  localparam int OP_OE     = 3;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic [7:0] expQ;
    logic       expP9;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p14 = 1'b0;
  logic p11 = 1'b0;
  logic p12 = 1'b0;
  logic p10 = 1'b1;
  logic p13 = 1'b0;
  wire  p15w, p1w, p2w, p3w, p4w, p5w, p6w, p7w;
  wire  p9w;
  logic [7:0] q;

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs[$];

  // Released outputs float up, so high-Z reads as ones on the bus
  pullup (p15w);
  pullup (p1w);
  pullup (p2w);
  pullup (p3w);
  pullup (p4w);
  pullup (p5w);
  pullup (p6w);
  pullup (p7w);

  hc595 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .p14(p14), .p11(p11), .p12(p12), .p10(p10), .p13(p13),
    .p15(p15w), .p1(p1w), .p2(p2w), .p3(p3w), .p4(p4w),
    .p5(p5w), .p6(p6w), .p7(p7w), .p9(p9w)
  );

  assign q = {p7w, p6w, p5w, p4w, p3w, p2w, p1w, p15w};

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expQ, input logic expP9);
    nChecks++;
    if (q !== expQ || p9w !== expP9) begin
      nFails++;
      $display("[TB] FAIL %s: got q=%h p9=%b, expected q=%h p9=%b", name, q, p9w, expQ, expP9);
    end
  endtask

  task automatic shiftBit(input logic b);
    p14 = b;
    tick(1);
    p11 = 1'b1;
    tick(1);
    p11 = 1'b0;
    tick(1);
  endtask

  task automatic tiedPulse();
    p11 = 1'b1;
    p12 = 1'b1;
    tick(1);
    p11 = 1'b0;
    p12 = 1'b0;
    tick(2);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic applyStimulus(input int op, input logic [7:0] data);
    case (op)
      OP_SHIFT8: begin
        for (int i = 7; i >= 0; i--) shiftBit(data[i]);
        tick(2);
      end
      OP_LATCH: begin
        p12 = 1'b1;
        tick(1);
        p12 = 1'b0;
        tick(3);
      end
      OP_CLEAR: begin
        p10 = 1'b0;
        tick(2);
        p10 = 1'b1;
        tick(3);
      end
      default: begin
        p13 = data[0];
        #1;
      end
    endcase
  endtask

  initial begin
    // Clocks already high through reset release must not shift or latch
    p10 = 1'b1;
    p11 = 1'b1;
    p12 = 1'b1;
    p14 = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    checkOutput("prime idle", 8'h00, 1'b0);
    p11 = 1'b0;
    p12 = 1'b0;
    tick(3);
    for (int i = 0; i < 7; i++) shiftBit(1'b1);
    tick(2);
    checkOutput("prime 7 ones p9", 8'h00, 1'b0);
    applyStimulus(OP_LATCH, 8'h00);
    checkOutput("prime latch 7F", 8'h7F, 1'b0);

    doReset();
    checkOutput("reset state", 8'h00, 1'b0);

    vecs.push_back('{OP_SHIFT8, 8'hA5, 8'h00, 1'b1});
    vecs.push_back('{OP_LATCH,  8'h00, 8'hA5, 1'b1});
    vecs.push_back('{OP_SHIFT8, 8'h3C, 8'hA5, 1'b0});
    vecs.push_back('{OP_LATCH,  8'h00, 8'h3C, 1'b0});
    vecs.push_back('{OP_SHIFT8, 8'hFF, 8'h3C, 1'b1});
    vecs.push_back('{OP_CLEAR,  8'h00, 8'h3C, 1'b0});
    vecs.push_back('{OP_LATCH,  8'h00, 8'h00, 1'b0});
    vecs.push_back('{OP_SHIFT8, 8'h81, 8'h00, 1'b1});
    vecs.push_back('{OP_LATCH,  8'h00, 8'h81, 1'b1});
    vecs.push_back('{OP_OE,     8'h01, 8'hFF, 1'b1});
    vecs.push_back('{OP_OE,     8'h00, 8'h81, 1'b1});
    vecs.push_back('{OP_SHIFT8, 8'h42, 8'h81, 1'b0});
    vecs.push_back('{OP_OE,     8'h01, 8'hFF, 1'b0});
    vecs.push_back('{OP_LATCH,  8'h00, 8'hFF, 1'b0});
    vecs.push_back('{OP_OE,     8'h00, 8'h42, 1'b0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expP9);
    end

    // One pin driving both clocks leaves storage one shift behind
    doReset();
    p14 = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) tiedPulse();
    tick(1);
    checkOutput("tied 8 pulses", 8'h7F, 1'b1);
    tiedPulse();
    tick(1);
    checkOutput("tied 9 pulses", 8'hFF, 1'b1);

    // Reset in the middle of a load wipes everything at once
    for (int i = 0; i < 4; i++) shiftBit(1'b1);
    tick(2);
    checkOutput("partial load", 8'hFF, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async reset", 8'h00, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(4);
    applyStimulus(OP_SHIFT8, 8'h5A);
    checkOutput("reload before latch", 8'h00, 1'b0);
    applyStimulus(OP_LATCH, 8'h00);
    checkOutput("reload 5A", 8'h5A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
